// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with
// memory-timeout and illegal-opcode traps plus a retired-instruction counter.
module multicycle_control_fsm #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  input  logic             trap_clr,
  output logic             imem_req,
  output logic             instr_en,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
  localparam logic [2:0] S_TRAP    = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam int unsigned     WAIT_W     = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT != 0);

  logic [2:0]        state_q, state_d;
  logic [1:0]        cause_q, cause_d;
  logic [WAIT_W-1:0] wait_cnt;
  logic              retire;
  logic              legal;
  logic              timed_out;
  logic              waiting;

  assign state      = state_q;
  assign trap_cause = cause_q;

  always_comb begin
    case (opcode)
      OP_LOAD, OP_STORE, OP_OP, OP_IMM, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
  end

  // Counter never passes WAIT_MAX: reaching it with ready low leaves the state.
  assign timed_out = TIMEOUT_EN && (wait_cnt == WAIT_MAX);
  assign waiting   = ((state_q == S_FETCH) && !imem_ready) ||
                     ((state_q == S_MEM)   && !dmem_ready);

  always_comb begin
    imem_req  = 1'b0;
    instr_en  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    trap      = 1'b0;
    retire    = 1'b0;
    state_d   = state_q;
    cause_d   = cause_q;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          instr_en = 1'b1;
          state_d  = S_DECODE;
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = 2'b10;
        end
      end
      S_DECODE: begin
        if (legal) begin
          state_d = S_EXECUTE;
        end else begin
          state_d = S_TRAP;
          cause_d = 2'b01;
        end
      end
      S_EXECUTE: begin
        if (opcode == OP_BRANCH) begin
          pc_write = 1'b1;
          pc_src   = branch_taken ? 2'b01 : 2'b00;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end else if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_STORE);
        if (dmem_ready) begin
          if (opcode == OP_STORE) begin
            pc_write = 1'b1;
            retire   = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timed_out) begin
          state_d = S_TRAP;
          cause_d = 2'b11;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
        if (opcode == OP_LOAD)                            wb_sel = 2'b01;
        else if ((opcode == OP_JAL) || (opcode == OP_JALR)) wb_sel = 2'b10;
        if (opcode == OP_JAL)       pc_src = 2'b01;
        else if (opcode == OP_JALR) pc_src = 2'b10;
      end
      S_TRAP: begin
        trap = 1'b1;
        if (trap_clr) begin
          state_d = S_FETCH;
          cause_d = 2'b00;
        end
      end
      default: begin
        state_d = S_TRAP;
        cause_d = 2'b01;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      cause_q  <= 2'b00;
      wait_cnt <= '0;
      instret  <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (retire) instret <= instret + CNT_W'(1);
      if (state_d != state_q)          wait_cnt <= '0;
      else if (waiting && TIMEOUT_EN)  wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed scenarios then random instructions,
// each expanded into an expected per-cycle trace from the sequencing rules.
module tb_multicycle_control_fsm;

  localparam int unsigned TO = 4;

  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, OPR = 7'b0110011,
                         OPI = 7'b0010011, BRANCH = 7'b1100011, JAL = 7'b1101111,
                         JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

  logic        clk = 1'b0;
  logic        rst_n, branch_taken, imem_ready, dmem_ready, trap_clr;
  logic [6:0]  opcode;
  logic        imem_req, instr_en, pc_write, dmem_req, dmem_we, reg_write, trap;
  logic [1:0]  pc_src, wb_sel, trap_cause;
  logic [2:0]  state;
  logic [31:0] instret;
  logic [15:0] obs_v;

  int total = 0;
  int bad   = 0;
  int unsigned mdl_ret = 0;

  typedef struct {
    logic [2:0]  st;
    logic [12:0] o;
    logic        ir, dr, tc;
  } exp_t;
  exp_t exp_q[$];

  logic [6:0] legal_ops [9] = '{LOAD, STORE, OPR, OPI, BRANCH, JAL, JALR, LUI, AUIPC};

  multicycle_control_fsm #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .trap_clr(trap_clr),
    .imem_req(imem_req), .instr_en(instr_en), .pc_write(pc_write), .pc_src(pc_src),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .reg_write(reg_write), .wb_sel(wb_sel),
    .trap(trap), .trap_cause(trap_cause), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  assign obs_v = {state, imem_req, instr_en, pc_write, pc_src, dmem_req, dmem_we,
                  reg_write, wb_sel, trap, trap_cause};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [12:0] outs(input logic ireq, ien, pcw, input logic [1:0] psrc,
                                       input logic dreq, dwe, rw, input logic [1:0] wsel,
                                       input logic tr, input logic [1:0] cause);
    return {ireq, ien, pcw, psrc, dreq, dwe, rw, wsel, tr, cause};
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    for (int unsigned i = 0; i < 9; i++) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input logic [2:0] st, input logic [12:0] o,
                      input logic ir, input logic dr, input logic tc);
    exp_t e;
    e.st = st; e.o = o; e.ir = ir; e.dr = dr; e.tc = tc;
    exp_q.push_back(e);
  endtask

  task automatic trap_seq(input logic [1:0] cause, input int unsigned hold);
    for (int unsigned i = 0; i < hold; i++)
      push(3'd7, outs(0,0,0,2'b00,0,0,0,2'b00,1,cause), 0, 0, 0);
    push(3'd7, outs(0,0,0,2'b00,0,0,0,2'b00,1,cause), 0, 0, 1);
  endtask

  // Expected trace of one instruction: iw/dw are ready-low cycles before ready.
  task automatic plan(input logic [6:0] op, input int unsigned iw, input int unsigned dw,
                      input logic bt, input int unsigned hold);
    logic ld, st;
    logic [1:0] ws, ps;
    ld = (op == LOAD);
    st = (op == STORE);
    opcode = op;
    branch_taken = bt;
    for (int unsigned k = 0; k < iw && k <= TO; k++)
      push(3'd0, outs(1,0,0,2'b00,0,0,0,2'b00,0,2'b00), 0, 0, 0);
    if (iw > TO) begin trap_seq(2'b10, hold); return; end
    push(3'd0, outs(1,1,0,2'b00,0,0,0,2'b00,0,2'b00), 1, 0, 0);
    push(3'd1, '0, 0, 0, 0);
    if (!is_legal(op)) begin trap_seq(2'b01, hold); return; end
    if (op == BRANCH) begin
      push(3'd2, outs(0,0,1,{1'b0,bt},0,0,0,2'b00,0,2'b00), 0, 0, 0);
      mdl_ret++;
      return;
    end
    push(3'd2, '0, 0, 0, 0);
    if (ld || st) begin
      for (int unsigned k = 0; k < dw && k <= TO; k++)
        push(3'd3, outs(0,0,0,2'b00,1,st,0,2'b00,0,2'b00), 0, 0, 0);
      if (dw > TO) begin trap_seq(2'b11, hold); return; end
      push(3'd3, outs(0,0,st,2'b00,1,st,0,2'b00,0,2'b00), 0, 1, 0);
      if (st) begin mdl_ret++; return; end
    end
    ws = ld ? 2'b01 : ((op == JAL || op == JALR) ? 2'b10 : 2'b00);
    ps = (op == JAL) ? 2'b01 : ((op == JALR) ? 2'b10 : 2'b00);
    push(3'd4, outs(0,0,1,ps,0,0,1,ws,0,2'b00), 0, 0, 0);
    mdl_ret++;
  endtask

  task automatic run_q();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      imem_ready = e.ir;
      dmem_ready = e.dr;
      trap_clr   = e.tc;
      @(negedge clk);
      chk($sformatf("cycle_st%0d_op%b", e.st, opcode), {16'h0, obs_v}, {16'h0, e.st, e.o});
      @(posedge clk);
      #1;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    trap_clr   = 1'b0;
    #1;
    chk("end_state", {29'h0, state}, 32'd0);
    chk("end_cause", {30'h0, trap_cause}, 32'd0);
    chk("instret", instret, mdl_ret);
  endtask

  task automatic do_instr(input logic [6:0] op, input int unsigned iw, input int unsigned dw,
                          input logic bt, input int unsigned hold);
    plan(op, iw, dw, bt, hold);
    run_q();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_outs"}, {16'h0, obs_v}, {16'h0, 3'd0, outs(1,0,0,2'b00,0,0,0,2'b00,0,2'b00)});
    chk({tag, "_instret"}, instret, 32'd0);
  endtask

  initial begin
    logic [6:0] op;
    int unsigned sel;
    rst_n = 1'b0; opcode = '0; branch_taken = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; trap_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    mdl_ret = 0;
    #1;
    check_reset_outputs("reset");

    do_instr(OPR, 2, 0, 1'b0, 0);       // fetch waits two cycles
    do_instr(LOAD, 0, 3, 1'b0, 0);
    do_instr(STORE, 0, 0, 1'b0, 0);
    do_instr(BRANCH, 0, 0, 1'b1, 0);
    do_instr(BRANCH, 0, 0, 1'b0, 0);
    do_instr(7'b0000000, 0, 0, 1'b0, 10);
    do_instr(OPR, 5, 0, 1'b0, 2);       // imem timeout
    do_instr(OPR, 4, 0, 1'b0, 0);       // ready on last allowed cycle
    do_instr(LOAD, 0, 5, 1'b0, 1);      // dmem timeout
    do_instr(STORE, 1, 4, 1'b0, 0);
    do_instr(JAL, 0, 0, 1'b0, 0);
    do_instr(JALR, 0, 0, 1'b0, 0);
    do_instr(LUI, 0, 0, 1'b0, 0);

    // reset in the middle of a data access
    opcode = LOAD;
    imem_ready = 1'b1;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("pre_reset_mem", {29'h0, state}, 32'd3);
    chk("pre_reset_dreq", {31'h0, dmem_req}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdl_ret = 0;
    #1;
    check_reset_outputs("mid_mem_reset");

    for (int unsigned n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 10);
      if (sel < 9)       op = legal_ops[sel];
      else if (sel == 9) op = 7'b0000000;
      else               op = 7'($urandom);
      do_instr(op, $urandom_range(0, 5), $urandom_range(0, 5),
               1'($urandom), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
